// File: rtl/regfile_array_pkg.sv
// Shared defaults and types for the regfile_array register file.
package regfile_array_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_REGS   = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_REG           = 0;

    typedef logic [DEFAULT_NUM_REGS-1:0][DEFAULT_DATA_WIDTH-1:0] reg_array_t;

endpackage

// File: rtl/regfile_array_cell.sv
// Single register-file word: write-enabled flop with synchronous active-high reset.
module regfile_cell #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        data_d = wr_en_i ? wr_data_i : data_q;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data_o = data_q;

endmodule

// File: rtl/regfile_array.sv
// 32x32 register file fed by a one-hot write select; two combinational read ports.
// Optional same-cycle write-to-read bypass is compiled in with REGFILE_WRITE_BYPASS_EN.
module regfile_array
    import regfile_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic [NUM_REGS-1:0]   ctrl_writeSel,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  err_multiHot
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  multi_hot;
    logic                  err_multi_hot_d;
    logic                  err_multi_hot_q;

    // Bit 0 counts toward the popcount even though register 0 is never stored.
    always_comb begin : onehot_check
        logic seen;
        seen      = 1'b0;
        multi_hot = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ctrl_writeSel[i]) begin
                if (seen) begin
                    multi_hot = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    assign regs[ZERO_REG] = '0;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_cell
        regfile_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .clock     (clock),
            .ctrl_reset(ctrl_reset),
            .wr_en_i   (ctrl_writeSel[k] & ~multi_hot),
            .wr_data_i (data_writeReg),
            .rd_data_o (regs[k])
        );
    end

    always_comb begin
        err_multi_hot_d = err_multi_hot_q | multi_hot;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            err_multi_hot_q <= 1'b0;
        end else begin
            err_multi_hot_q <= err_multi_hot_d;
        end
    end

    assign err_multiHot = err_multi_hot_q;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass_ok;

    // A set select bit with no multi-hot means exactly that register is being written.
    always_comb begin
        bypass_ok     = ~ctrl_reset & ~multi_hot;
        data_readRegA = regs[ctrl_readRegA];
        data_readRegB = regs[ctrl_readRegB];
        if (bypass_ok && (ctrl_readRegA != ADDR_WIDTH'(ZERO_REG))
                && ctrl_writeSel[ctrl_readRegA]) begin
            data_readRegA = data_writeReg;
        end
        if (bypass_ok && (ctrl_readRegB != ADDR_WIDTH'(ZERO_REG))
                && ctrl_writeSel[ctrl_readRegB]) begin
            data_readRegB = data_writeReg;
        end
    end
`else
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        data_readRegB = regs[ctrl_readRegB];
    end
`endif

endmodule

// File: tb/tb_regfile_array.sv
// Self-checking bench for regfile_array: directed plan followed by random traffic vs. an array model.
module tb_regfile_array;
    import regfile_array_pkg::*;

    logic        clock;
    logic        ctrl_reset;
    logic [31:0] ctrl_writeSel;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        err_multiHot;

    int checks;
    int failures;

    reg_array_t model;
    logic       model_err;

    regfile_array u_dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .ctrl_writeSel(ctrl_writeSel),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB),
        .err_multiHot (err_multiHot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!ctrl_reset && $countones(ctrl_writeSel) == 1 && ctrl_writeSel[addr])
            return data_writeReg;
`endif
        return model[addr];
    endfunction

    task automatic apply(input logic rst, input logic [31:0] sel, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        ctrl_reset    = rst;
        ctrl_writeSel = sel;
        data_writeReg = wd;
        ctrl_readRegA = ra;
        ctrl_readRegB = rb;
        #2;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = exp_read(ctrl_readRegA);
        eb = exp_read(ctrl_readRegB);
        check32({tag, "_rdA"}, data_readRegA, ea);
        check32({tag, "_rdB"}, data_readRegB, eb);
        checks++;
        assert (err_multiHot === model_err) else begin
            failures++;
            $error("FAIL %s_err observed=%0b expected=%0b", tag, err_multiHot, model_err);
        end
    endtask

    // Advance one rising edge and apply the architectural rules to the model.
    task automatic edge_update();
        int n;
        @(posedge clock);
        n = $countones(ctrl_writeSel);
        if (ctrl_reset) begin
            model     = '0;
            model_err = 1'b0;
        end else if (n > 1) begin
            model_err = 1'b1;
        end else if (n == 1 && !ctrl_writeSel[0]) begin
            model[$clog2(ctrl_writeSel)] = data_writeReg;
        end
        #1;
    endtask

    task automatic step(input string tag, input logic rst, input logic [31:0] sel,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        apply(rst, sel, wd, ra, rb);
        check_outputs(tag);
        edge_update();
    endtask

    initial begin
        logic [31:0] sel;
        int          b0;
        int          b1;
        checks    = 0;
        failures  = 0;
        model     = '0;
        model_err = 1'b0;

        // Reset without checking: pre-reset contents are unknown.
        @(negedge clock);
        apply(1'b1, 32'h0, 32'h0, 5'd0, 5'd0);
        edge_update();

        step("rst_addr0", 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        step("rst_addr5", 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        step("rst_addr31", 1'b0, 32'h0, 32'h0, 5'd31, 5'd31);

        // Write reg5; port B reads reg5 in the write cycle.
        step("wr5_same", 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 5'd5);
        step("wr5_next", 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        check32("wr5_value", data_readRegA, 32'hDEAD_BEEF);

        // Select of register 0 is legal but never stored.
        step("wr0", 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step("wr0_after", 1'b0, 32'h0, 32'h0, 5'd0, 5'd5);
        check32("wr0_zero", data_readRegA, 32'h0);

        // Multi-hot suppression and sticky flag.
        step("pre3", 1'b0, 32'h0000_0008, 32'h1111_1111, 5'd3, 5'd7);
        step("pre7", 1'b0, 32'h0000_0080, 32'h2222_2222, 5'd3, 5'd7);
        step("mh", 1'b0, 32'h0000_0088, 32'h1234_5678, 5'd3, 5'd7);
        step("mh_after", 1'b0, 32'h0, 32'h0, 5'd3, 5'd7);
        check32("mh_reg3", data_readRegA, 32'h1111_1111);
        check32("mh_reg7", data_readRegB, 32'h2222_2222);
        check32("mh_flag", {31'h0, err_multiHot}, 32'h1);
        step("mh_b0", 1'b0, 32'h0000_0005, 32'h5555_5555, 5'd2, 5'd0);
        step("mh_legal", 1'b0, 32'h0000_0200, 32'h0000_0909, 5'd2, 5'd9);
        step("mh_sticky", 1'b0, 32'h0, 32'h0, 5'd9, 5'd2);

        // Reset has priority over a concurrent write.
        step("w31", 1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 5'd31, 5'd0);
        step("rst_w31", 1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 5'd31, 5'd31);
        step("rst_after", 1'b0, 32'h0, 32'h0, 5'd31, 5'd31);

        // Fill and sweep.
        for (int k = 1; k < 32; k++) begin
            step("fill", 1'b0, 32'h1 << k, 32'h0101_0101 * k, 5'(k), 5'(k - 1));
        end
        for (int a = 0; a < 32; a++) begin
            step("sweep", 1'b0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
        end

        // Random traffic: mix of idle, one-hot, multi-hot and occasional reset.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    sel = 32'h0;
                2:       begin
                    b0  = $urandom_range(0, 31);
                    b1  = (b0 + $urandom_range(1, 31)) % 32;
                    sel = (32'h1 << b0) | (32'h1 << b1);
                end
                default: sel = 32'h1 << $urandom_range(0, 31);
            endcase
            step("rand", ($urandom_range(0, 39) == 0), sel, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_array.md
Name: regfile_array

Overview:
- 32-entry x 32-bit register file core that sits directly downstream of the 5-to-32 write-address decoder.
- Consumes the decoder's one-hot write-select vector, already gated by write enable, and latches write data into the selected register on the clock edge.
- Provides two independent read ports addressed by 5-bit register numbers.
- Register 0 reads as constant zero.

Parameters:
DATA_WIDTH, 32, width of each register and of the write/read data buses
NUM_REGS, 32, number of registers; equals the width of the write-select vector
ADDR_WIDTH, 5, read-address width; must satisfy 2**ADDR_WIDTH == NUM_REGS

Ports:
clock  input  1  single design clock; all state updates on rising edge
ctrl_reset  input  1  synchronous, active-high reset
ctrl_writeSel  input  NUM_REGS  one-hot write select from the decoder; all-zero means no write
data_writeReg  input  DATA_WIDTH  write data
ctrl_readRegA  input  ADDR_WIDTH  read port A register number
ctrl_readRegB  input  ADDR_WIDTH  read port B register number
data_readRegA  output  DATA_WIDTH  read port A data
data_readRegB  output  DATA_WIDTH  read port B data
err_multiHot  output  1  sticky flag: a write-select vector with more than one bit set was presented

Behaviour:
- Interface: one clock, `clock`; reset `ctrl_reset` is synchronous and active-high.
- Reset: on a rising edge with ctrl_reset=1, all registers clear to 0 and err_multiHot clears to 0. Any write in that cycle is discarded; reset has priority.
- Write:
  - Rising edge with ctrl_reset=0 and exactly one bit k set in ctrl_writeSel: reg[k] <= data_writeReg.
  - Write latency is 1 cycle; the value is visible on the read ports from the next cycle.
  - All-zero ctrl_writeSel: no state change.
- Register 0: ctrl_writeSel[0] is accepted as a legal one-hot value but is never stored. reg[0] is always 0 and has no storage flop.
- Multi-hot select (popcount > 1): the entire write is suppressed, no register changes, and err_multiHot <= 1 at that edge. The flag stays 1 until reset.
  - Bit 0 counts toward popcount. Selects of 0x00000001 | 0x00000004 are therefore multi-hot and suppressed.
- Reads: combinational (zero latency) from the current register contents.
  - Address 0 returns 0.
  - Both ports may read the same address simultaneously.
  - Read data is independent of ctrl_writeSel unless the bypass feature below is compiled in.
- Read/write to the same address in the same cycle, without bypass: returns the old value; the new value appears next cycle.
- Reset mid-stream: registers written before reset read 0 on the cycle after the reset edge.
- Outputs after reset: data_readRegA = data_readRegB = 0 for any address. err_multiHot = 0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if ctrl_writeSel selects exactly one register k != 0, ctrl_reset=0, and a read address equals k, that port returns data_writeReg combinationally in the same cycle.
  - Address 0 is never bypassed.
  - Multi-hot or reset cycles are never bypassed.
- Undefined: reads always return stored contents; same-cycle write data is not visible until the next cycle.

Decomposition:
- Shared package: DATA_WIDTH, NUM_REGS and ADDR_WIDTH defaults; a ZERO_REG index constant (0); a register-array typedef (array of NUM_REGS DATA_WIDTH-bit words).
- One sub-module, regfile_cell: a DATA_WIDTH-bit register with write enable and synchronous active-high reset, instantiated for indices 1..NUM_REGS-1.
- Kept in the top level:
  - the popcount/one-hot check;
  - the two read multiplexers;
  - the bypass compare.

Test Plan:
- Reset, then read addresses 0, 5 and 31 on both ports -> all 0; err_multiHot=0.
- Write select 0x00000020 with data 0xDEADBEEF, next cycle read A=5 -> 0xDEADBEEF; same cycle read B=5 -> 0 without bypass, 0xDEADBEEF with REGFILE_WRITE_BYPASS_EN.
- Write select 0x00000001 with data 0xFFFFFFFF -> read A=0 returns 0; err_multiHot stays 0.
- Preload reg3=0x11111111 and reg7=0x22222222; apply select 0x00000088 with data 0x12345678 -> reg3 and reg7 unchanged; err_multiHot=1 from the next cycle and it remains 1 after later legal writes.
- Write reg31=0xA5A5A5A5; assert ctrl_reset for one cycle together with a write of 0x0F0F0F0F to reg31 -> read 31 returns 0 after the edge; err_multiHot=0.
- Write each register k=1..31 with value k*0x01010101, then sweep both ports over all addresses -> each returns its value and address 0 returns 0.
